// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port Memoria between instruction fetch and data load/store.
// Define MEMARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            owner_q, owner_d;
    logic              store_q, store_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              data_wins;
    logic              if_gnt_w, d_gnt_w;

`ifdef MEMARB_RR_EN
    owner_t last_q, last_d;
    // Under contention the port that did not win the previous handshake goes first.
    assign data_wins = d_req && (!if_req || (last_q == OWN_FETCH));
`else
    assign data_wins = d_req;
`endif

    // Grants are combinational and held off entirely while reset is asserted.
    assign d_gnt_w  = reset && (state_q == IDLE) && data_wins;
    assign if_gnt_w = reset && (state_q == IDLE) && if_req && !data_wins;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        store_d     = store_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef MEMARB_RR_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (d_gnt_w || if_gnt_w) begin
                    owner_d     = d_gnt_w ? OWN_DATA : OWN_FETCH;
                    store_d     = d_gnt_w && d_we;
                    mem_we_d    = d_gnt_w && d_we;
                    mem_addr_d  = d_gnt_w ? d_addr : if_addr;
                    mem_wdata_d = d_gnt_w ? d_wdata : mem_wdata_q;
                    cnt_d       = (d_gnt_w && d_we) ? '0 : CNT_W'(MEM_LAT - 1);
                    state_d     = WAIT;
`ifdef MEMARB_RR_EN
                    last_d      = d_gnt_w ? OWN_DATA : OWN_FETCH;
`endif
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!store_q) begin
                        if (owner_q == OWN_DATA) d_rdata_d  = mem_rdata;
                        else                     if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: flops use non-blocking assignments so each register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_FETCH;
            store_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef MEMARB_RR_EN
            last_q      <= OWN_FETCH;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            store_q     <= store_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEMARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign if_gnt    = if_gnt_w;
    assign d_gnt     = d_gnt_w;
    assign if_rvalid = (state_q == RESP) && (owner_q == OWN_FETCH);
    assign d_rvalid  = (state_q == RESP) && (owner_q == OWN_DATA);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port `Memoria` between instruction fetch and data load/store. The control unit raises a fetch or data request. The arbiter grants one of them, drives `Memoria` address/write/write-data, waits the fixed memory read latency, and returns read data or a write acknowledge to the winner. It sits between `ctrl_unit`/datapath and `Memoria`, and replaces the direct PC-to-memory address path.

## Interface
- `MEM_LAT`, 2: `Memoria` read latency in cycles, from `mem_addr` valid to `mem_rdata` valid; legal values are ≥1.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 resets.
- `if_req`  in  1  fetch request; read only.
- `if_addr`  in  ADDR_W  fetch address; sampled on handshake.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  DATA_W  fetched word.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load; sampled on handshake.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data accepted this cycle.
- `d_rvalid`  out  1  one-cycle pulse; load data valid, or store acknowledge.
- `d_rdata`  out  DATA_W  loaded word.
- `mem_addr`  out  ADDR_W  to `Memoria` address.
- `mem_we`  out  1  to `Memoria` write enable.
- `mem_wdata`  out  DATA_W  to `Memoria` data in.
- `mem_rdata`  in  DATA_W  from `Memoria` data out.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `*_gnt` is combinational: it is asserted only in IDLE, only to the arbitration winner, and only while that requester's `*_req` = 1.
  - A handshake is `req && gnt` at a rising edge.
  - On handshake, the arbiter registers the address, `we` (forced to 0 for fetch), write data and owner into the `mem_*` output registers.
  - It also loads `cnt = MEM_LAT-1` (for a store, `cnt = 0`) and moves to WAIT.
- **WAIT**
  - `mem_addr`/`mem_wdata` stay stable.
  - `mem_we` = 1 only for a store, and only in the first WAIT cycle.
  - `cnt` decrements each cycle.
  - When `cnt` = 0, the arbiter moves to RESP. For a load or fetch, it captures `mem_rdata` into the owner's `*_rdata` at that edge.
- **RESP**
  - The owner's `*_rvalid` = 1 for exactly one cycle.
  - No grant is given. Next state is IDLE.
- `*_rdata` holds its last captured value until the next read for that port; a store does not change `d_rdata`.
- After a handshake, `*_req` is ignored until RESP.
- A requester may drop `*_req` before it is granted; nothing happens.
- `cnt` width is `$clog2(MEM_LAT+1)`.
- Default arbitration, with both requests high in IDLE: data wins.

## Timing
- Handshake at cycle T.
- Read (fetch or load):
  - `mem_addr` is valid from T+1.
  - `mem_rdata` is sampled at the end of T+MEM_LAT.
  - `*_rvalid` is high in T+MEM_LAT+1.
  - Latency is MEM_LAT+1.
- Store:
  - `mem_we` = 1 in T+1 only.
  - `d_rvalid` is high in T+2.
- Earliest next grant: T+MEM_LAT+2 for a read, T+3 for a store.
- Values on `reset` = 0 (all immediate, asynchronous):
  - State IDLE and `cnt` = 0.
  - `mem_addr`, `mem_wdata`, `*_rdata` = 0.
  - `mem_we`, `*_rvalid` = 0.
  - Owner and round-robin pointer set to "fetch last".
  - `*_gnt` = 0 while reset is low.
- Reset mid-transaction aborts it:
  - `mem_we` drops immediately.
  - No `rvalid` is issued.
  - The first grant is possible in the first clock with `reset` = 1.

## Configuration
- `MEMARB_RR_EN` defined: round-robin arbitration.
  - With both requests high in IDLE, the port not granted last wins.
  - A one-bit pointer updates on every handshake, including uncontended ones.
- Not defined: fixed priority, data over fetch. The pointer logic is not compiled in.

## Test plan
- Reset: hold `reset` = 0 with `if_req` = `d_req` = 1 for 5 cycles. All outputs stay 0 and no gnt is asserted. Release reset: `d_gnt` = 1 in the first cycle.
- Fetch read, MEM_LAT = 2, `if_addr` = 0x10, memory returns 0xDEADBEEF:
  - `if_gnt` high at T.
  - `mem_addr` = 0x10 at T+1.
  - `if_rvalid` = 1 with `if_rdata` = 0xDEADBEEF at T+3 only.
- Store, `d_addr` = 0x20, `d_wdata` = 0x1234:
  - `mem_we` = 1 at T+1 only.
  - `d_rvalid` at T+2.
  - `d_rdata` unchanged.
  - Read-back load of 0x20 returns 0x1234 at T'+3.
- Both requests held high for 4 transactions:
  - Without the macro: grants are d, d, d, d.
  - With `MEMARB_RR_EN`: grants are d, if, d, if.
  - Grants are MEM_LAT+2 cycles apart.
- Reset mid-store: assert `reset` = 0 during T+1. `mem_we` falls in the same cycle and no `d_rvalid` ever pulses for that store.
